// File: rtl/spine_pkg.sv
// Shared widths and flit helpers for the spine-side crossbar.
package spine_pkg;

    localparam int unsigned FLIT_W  = 16;
    localparam int unsigned DEST_W  = 6;
    localparam int unsigned GRP_W   = 4;
    localparam int unsigned GRP_LSB = FLIT_W - GRP_W;

    function automatic logic [DEST_W-1:0] dest_of(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_W-1 -: DEST_W];
    endfunction

endpackage

// File: rtl/spine_fifo.sv
// Synchronous input FIFO; a write is accepted while full if a read happens in the same cycle.
module spine_fifo #(
    parameter int unsigned Width = 16,
    parameter int unsigned Depth = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             rd_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             wr_en, rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign rd_en = rd_i && !empty_o;
    assign wr_en = wr_i && (!full_o || rd_en);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !reset_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spine_switch.sv
// Spine crossbar: buffered leaf inputs, group-based routing, per-output round-robin,
// registered outputs, and drop/overflow/misroute accounting.
module spine_switch
    import spine_pkg::*;
#(
    parameter int unsigned       NUM_PORTS  = 4,
    parameter int unsigned       DWIDTH     = FLIT_W,
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter logic [GRP_W-1:0]  GROUP_BASE = 4'd0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_PORTS*DWIDTH-1:0]   leaf_in_data_i,
    input  logic [NUM_PORTS-1:0]          leaf_in_valid_i,
    output logic [NUM_PORTS*DWIDTH-1:0]   leaf_out_data_o,
    output logic [NUM_PORTS-1:0]          leaf_out_valid_o,
    output logic [NUM_PORTS*DEST_W-1:0]   leaf_out_dest_o,
    output logic [7:0]                    drop_count_o,
    output logic [NUM_PORTS-1:0]          overflow_flag_o,
    output logic                          misroute_flag_o
);
    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [DWIDTH-1:0]           head      [NUM_PORTS];
    logic [GRP_W-1:0]            head_port [NUM_PORTS];
    logic [NUM_PORTS-1:0]        empty, full, pop, push, ovf_drop, misroute;

    logic [PW-1:0]               rr_q [NUM_PORTS];
    logic [PW-1:0]               rr_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]        gnt_valid;
    logic [PW-1:0]               gnt_idx [NUM_PORTS];

    logic [NUM_PORTS*DWIDTH-1:0] out_data_q;
    logic [NUM_PORTS-1:0]        out_valid_q;
    logic [NUM_PORTS*DEST_W-1:0] out_dest_q;
    logic [7:0]                  drop_q, drop_d;
    logic [NUM_PORTS-1:0]        ovf_q;
    logic                        mis_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_in
        // Port index relative to this spine's first group; wraps in 4 bits.
        assign head_port[p] = head[p][DWIDTH-1 -: GRP_W] - GROUP_BASE;
        assign misroute[p]  = !empty[p] && (32'(head_port[p]) >= NUM_PORTS);
        assign push[p]      = leaf_in_valid_i[p] && (!full[p] || pop[p]);
        assign ovf_drop[p]  = leaf_in_valid_i[p] && full[p] && !pop[p];

        spine_fifo #(
            .Width (DWIDTH),
            .Depth (FIFO_DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .wr_i    (push[p]),
            .wdata_i (leaf_in_data_i[p*DWIDTH +: DWIDTH]),
            .rd_i    (pop[p]),
            .rdata_o (head[p]),
            .full_o  (full[p]),
            .empty_o (empty[p])
        );
    end

    // Each head targets exactly one output, so the per-output scans never grant the same input twice.
    always_comb begin
        logic [PW-1:0] idx;
        idx = '0;
        pop = misroute;
        for (int unsigned o = 0; o < NUM_PORTS; o++) begin
            gnt_valid[o] = 1'b0;
            gnt_idx[o]   = '0;
            rr_d[o]      = rr_q[o];
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                idx = PW'((32'(rr_q[o]) + k) % NUM_PORTS);
                if (!gnt_valid[o] && !empty[idx] && (32'(head_port[idx]) == o)) begin
                    gnt_valid[o] = 1'b1;
                    gnt_idx[o]   = idx;
                    pop[idx]     = 1'b1;
                    rr_d[o]      = PW'((32'(idx) + 1) % NUM_PORTS);
                end
            end
        end
    end

    always_comb begin
        int unsigned drop_sum;
        int unsigned drop_next;
        drop_sum = 0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            drop_sum += 32'(ovf_drop[p]) + 32'(misroute[p]);
        end
        drop_next = 32'(drop_q) + drop_sum;
        drop_d    = (drop_next > 255) ? 8'hFF : 8'(drop_next);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q        <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= '0;
            out_dest_q  <= '0;
            drop_q      <= '0;
            ovf_q       <= '0;
            mis_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= gnt_valid;
            drop_q      <= drop_d;
            ovf_q       <= ovf_q | ovf_drop;
            mis_q       <= mis_q | (|misroute);
            for (int unsigned o = 0; o < NUM_PORTS; o++) begin
                if (gnt_valid[o]) begin
                    out_data_q[o*DWIDTH +: DWIDTH] <= head[gnt_idx[o]];
                    out_dest_q[o*DEST_W +: DEST_W] <= head[gnt_idx[o]][DWIDTH-1 -: DEST_W];
                end
            end
        end
    end

    assign leaf_out_data_o  = out_data_q;
    assign leaf_out_valid_o = out_valid_q;
    assign leaf_out_dest_o  = out_dest_q;
    assign drop_count_o     = drop_q;
    assign overflow_flag_o  = ovf_q;
    assign misroute_flag_o  = mis_q;

endmodule

// File: tb/tb_spine_switch.sv
// Self-checking bench for spine_switch: directed scenarios plus randomized traffic vs a queue model.
module tb_spine_switch;

    localparam int NP    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam logic [3:0] GBASE = 4'd0;

    logic             clk;
    logic             reset;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_valid;
    logic [NP*DW-1:0] out_data;
    logic [NP-1:0]    out_valid;
    logic [NP*6-1:0]  out_dest;
    logic [7:0]       drop;
    logic [NP-1:0]    ovf;
    logic             mis;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-input lists, per-output round-robin pointer, expected outputs.
    logic [15:0] mbuf [NP][DEPTH];
    int          mcnt [NP];
    int          rr_m [NP];
    logic [NP-1:0] ev;
    logic [15:0] ed [NP];
    int          edrop;
    logic [NP-1:0] eovf;
    logic        emis;

    spine_switch #(
        .NUM_PORTS  (NP),
        .DWIDTH     (DW),
        .FIFO_DEPTH (DEPTH),
        .GROUP_BASE (GBASE)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .leaf_in_data_i   (in_data),
        .leaf_in_valid_i  (in_valid),
        .leaf_out_data_o  (out_data),
        .leaf_out_valid_o (out_valid),
        .leaf_out_dest_o  (out_dest),
        .drop_count_o     (drop),
        .overflow_flag_o  (ovf),
        .misroute_flag_o  (mis)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int port_of(input logic [15:0] d);
        logic [3:0] g;
        g = d[15:12] - GBASE;
        return int'(g);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            mcnt[p] = 0;
            rr_m[p] = 0;
            ed[p]   = '0;
        end
        ev = '0; edrop = 0; eovf = '0; emis = 1'b0;
    endtask

    // Advance model by one clock edge using current inputs, then step the DUT.
    task automatic cycle();
        int nd;
        bit popped [NP];
        if (reset) begin
            model_reset();
        end else begin
            nd = 0;
            ev = '0;
            for (int p = 0; p < NP; p++) begin
                popped[p] = 1'b0;
                if (mcnt[p] > 0 && port_of(mbuf[p][0]) >= NP) begin
                    popped[p] = 1'b1; emis = 1'b1; nd++;
                end
            end
            for (int o = 0; o < NP; o++) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (rr_m[o] + k) % NP;
                    if (mcnt[p] > 0 && port_of(mbuf[p][0]) == o) begin
                        ev[o] = 1'b1; ed[o] = mbuf[p][0]; popped[p] = 1'b1;
                        rr_m[o] = (p + 1) % NP;
                        break;
                    end
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (popped[p]) begin
                    for (int j = 0; j < DEPTH - 1; j++) mbuf[p][j] = mbuf[p][j+1];
                    mcnt[p]--;
                end
                if (in_valid[p]) begin
                    if (mcnt[p] < DEPTH) begin
                        mbuf[p][mcnt[p]] = in_data[p*DW +: DW];
                        mcnt[p]++;
                    end else begin
                        eovf[p] = 1'b1; nd++;
                    end
                end
            end
            edrop = (edrop + nd > 255) ? 255 : edrop + nd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int p, input logic [15:0] d);
        in_data[p*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = '0; in_data = '0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int p = 0; p < NP; p++) set_in(p, 16'($urandom_range(0, 16'h3FFF)));
            in_valid = '1;
            cycle();
        end
        n_tests++; if (out_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %h expected 0", out_valid); end
        n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", out_data); end
        n_tests++; if (out_dest !== '0) begin n_fail++; $display("FAIL reset_dest: got %h expected 0", out_dest); end
        n_tests++; if (drop !== 8'd0) begin n_fail++; $display("FAIL reset_drop: got %0d expected 0", drop); end
        n_tests++; if (ovf !== '0 || mis !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b mis=%b expected 0", ovf, mis); end
        reset = 1'b0; in_valid = '0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin cycle(); if (out_valid != '0) seen++; end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL reset_ghost: got %0d valid cycles expected 0", seen); end
    endtask

    task automatic test_single();
        do_reset();
        set_in(0, 16'h0ABC); in_valid = 4'b0001;
        cycle();
        in_valid = '0;
        n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_early: got %b expected 0000", out_valid); end
        cycle();
        n_tests++; if (out_valid !== 4'b0001) begin n_fail++; $display("FAIL single_valid: got %b expected 0001", out_valid); end
        n_tests++; if (out_data[15:0] !== 16'h0ABC) begin n_fail++; $display("FAIL single_data: got %h expected 0abc", out_data[15:0]); end
        n_tests++; if (out_dest[5:0] !== 6'h02) begin n_fail++; $display("FAIL single_dest: got %h expected 02", out_dest[5:0]); end
        cycle();
        n_tests++; if (out_valid !== 4'b0000 || out_data[15:0] !== 16'h0ABC) begin
            n_fail++; $display("FAIL single_pulse: got valid=%b data=%h expected 0000/0abc", out_valid, out_data[15:0]);
        end
    endtask

    task automatic test_contention();
        logic [15:0] rec_d [$];
        int          rec_c [$];
        int          stray;
        do_reset();
        stray = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 4) begin
                for (int p = 0; p < NP; p++) set_in(p, 16'h2000 | 16'(p << 4) | 16'(c));
                in_valid = '1;
            end else in_valid = '0;
            cycle();
            if (out_valid[2]) begin rec_d.push_back(out_data[2*DW +: DW]); rec_c.push_back(c); end
            if ((out_valid & 4'b1011) != '0) stray++;
        end
        n_tests++; if (rec_d.size() != 16) begin n_fail++; $display("FAIL contend_count: got %0d expected 16", rec_d.size()); end
        n_tests++; if (stray != 0) begin n_fail++; $display("FAIL contend_stray: got %0d expected 0", stray); end
        for (int k = 0; k < rec_d.size() && k < 16; k++) begin
            n_tests++;
            if (rec_d[k] !== (16'h2000 | 16'((k % 4) << 4) | 16'(k / 4)) || rec_c[k] != k + 1) begin
                n_fail++;
                $display("FAIL contend_order[%0d]: got %h@%0d expected %h@%0d", k, rec_d[k], rec_c[k],
                         16'h2000 | 16'((k % 4) << 4) | 16'(k / 4), k + 1);
            end
        end
    endtask

    task automatic test_overflow();
        int delivered;
        do_reset();
        delivered = 0;
        for (int c = 0; c < 48; c++) begin
            if (c < 8) begin
                for (int p = 0; p < NP; p++) set_in(p, 16'h3000 | 16'(p << 4) | 16'(c));
                in_valid = '1;
            end else in_valid = '0;
            cycle();
            if (out_valid[3]) delivered++;
        end
        n_tests++; if (ovf[1] !== 1'b1) begin n_fail++; $display("FAIL ovf_flag1: got %b expected 1", ovf[1]); end
        n_tests++; if (int'(drop) != 32 - delivered) begin n_fail++; $display("FAIL ovf_drops: got %0d expected %0d", drop, 32 - delivered); end
        n_tests++; if (int'(drop) != edrop || ovf !== eovf) begin
            n_fail++; $display("FAIL ovf_model: got drop=%0d ovf=%b expected %0d/%b", drop, ovf, edrop, eovf);
        end
    endtask

    task automatic test_misroute();
        int seen;
        do_reset();
        seen = 0;
        set_in(0, 16'hF000); in_valid = 4'b0001;
        cycle();
        in_valid = '0;
        for (int c = 0; c < 3; c++) begin cycle(); if (out_valid != '0) seen++; end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL mis_valid: got %0d expected 0", seen); end
        n_tests++; if (mis !== 1'b1) begin n_fail++; $display("FAIL mis_flag: got %b expected 1", mis); end
        n_tests++; if (drop !== 8'd1) begin n_fail++; $display("FAIL mis_drop1: got %0d expected 1", drop); end
        in_valid = 4'b0001;
        for (int c = 0; c < 300; c++) cycle();
        in_valid = '0;
        for (int c = 0; c < 4; c++) cycle();
        n_tests++; if (drop !== 8'd255) begin n_fail++; $display("FAIL mis_sat: got %0d expected 255", drop); end
        n_tests++; if (ovf !== '0) begin n_fail++; $display("FAIL mis_noovf: got %b expected 0", ovf); end
    endtask

    task automatic test_parallel();
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                set_in(0, 16'h1000 | 16'(c)); set_in(1, 16'h0100 | 16'(c));
                in_valid = 4'b0011;
            end else in_valid = '0;
            cycle();
            if (c >= 1 && c <= 20) begin
                if (out_valid !== 4'b0011 || out_data[1*DW +: DW] !== (16'h1000 | 16'(c - 1))
                    || out_data[15:0] !== (16'h0100 | 16'(c - 1))) bad++;
            end
        end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL par_stream: got %0d bad cycles expected 0", bad); end
        n_tests++; if (drop !== 8'd0) begin n_fail++; $display("FAIL par_drop: got %0d expected 0", drop); end
        for (int c = 0; c < 5; c++) begin
            set_in(0, 16'h1000 | 16'(c)); set_in(1, 16'h0100 | 16'(c)); in_valid = 4'b0011;
            cycle();
        end
        reset = 1'b1;
        cycle();
        n_tests++; if (out_valid !== '0 || out_data !== '0 || drop !== 8'd0) begin
            n_fail++; $display("FAIL par_midreset: got valid=%b data=%h drop=%0d expected 0", out_valid, out_data, drop);
        end
        reset = 1'b0;
        set_in(0, 16'h1055); in_valid = 4'b0001;
        cycle();
        in_valid = '0;
        cycle();
        n_tests++; if (out_valid !== 4'b0010 || out_data[1*DW +: DW] !== 16'h1055) begin
            n_fail++; $display("FAIL par_after_reset: got %b/%h expected 0010/1055", out_valid, out_data[1*DW +: DW]);
        end
        bad = 0;
        for (int c = 0; c < 6; c++) begin cycle(); if (out_valid != '0) bad++; end
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL par_stale: got %0d expected 0", bad); end
    endtask

    task automatic test_random();
        int dens;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 100 == 0) dens = $urandom_range(20, 100);
            for (int p = 0; p < NP; p++) begin
                set_in(p, {4'($urandom_range(0, 5)), 12'($urandom)});
                in_valid[p] = ($urandom_range(1, 100) <= dens);
            end
            cycle();
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, ev); end
            for (int o = 0; o < NP; o++) begin
                if (ev[o]) begin
                    n_tests++;
                    if (out_data[o*DW +: DW] !== ed[o] || out_dest[o*6 +: 6] !== ed[o][15:10]) begin
                        n_fail++;
                        $display("FAIL rnd_data%0d@%0d: got %h/%h expected %h/%h", o, c,
                                 out_data[o*DW +: DW], out_dest[o*6 +: 6], ed[o], ed[o][15:10]);
                    end
                end
            end
            n_tests++;
            if (int'(drop) != edrop || ovf !== eovf || mis !== emis) begin
                n_fail++;
                $display("FAIL rnd_stats@%0d: got drop=%0d ovf=%b mis=%b expected %0d/%b/%b", c, drop, ovf,
                         mis, edrop, eovf, emis);
            end
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = '0; in_data = '0;
        model_reset();
        test_reset();
        test_single();
        test_contention();
        test_overflow();
        test_misroute();
        test_parallel();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
